// File: rtl/ibex_pkg.sv
// Shared types and defaults for the writeback result buffer.
// Parity field of wb_entry_t exists only when WB_RESULT_PARITY_EN is defined.
package ibex_pkg;

  localparam int unsigned WB_DEPTH_DEFAULT = 4;
  localparam int unsigned WB_AW_DEFAULT    = 5;
  localparam int unsigned WB_DW_DEFAULT    = 32;

  typedef struct packed {
    logic [WB_AW_DEFAULT-1:0] rd;
    logic [WB_DW_DEFAULT-1:0] data;
`ifdef WB_RESULT_PARITY_EN
    logic                     par;
`endif
  } wb_entry_t;

  // Even parity: stored bit makes the XOR over {rd, data, par} zero.
  function automatic logic wb_parity(input logic [WB_AW_DEFAULT-1:0] rd,
                                     input logic [WB_DW_DEFAULT-1:0] data);
    return ^{rd, data};
  endfunction

endpackage

// File: rtl/ibex_wb_fwd_match.sv
// Youngest-first lookup of a register address over the pending result entries.
module ibex_wb_fwd_match #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32,
  parameter int unsigned PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [DEPTH-1:0][AW-1:0] rd_i,
  input  logic [DEPTH-1:0][DW-1:0] data_i,
  input  logic [PW-1:0]            wr_ptr_i,
  input  logic [AW-1:0]            addr_i,
  output logic                     hit_o,
  output logic [DW-1:0]            data_o
);

  logic [PW-1:0] idx;

  // Walk from the oldest slot (wr_ptr) to the youngest (wr_ptr-1); last match wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = wr_ptr_i + PW'(k);
      if (valid_i[idx] && (rd_i[idx] == addr_i) && (addr_i != '0)) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end

endmodule

// File: rtl/ibex_wb_result_buffer.sv
// Writeback result FIFO with register-file drain and rs1/rs2 forwarding.
// Optional per-entry parity protection enabled by defining WB_RESULT_PARITY_EN.
module ibex_wb_result_buffer
  import ibex_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH_DEFAULT,
  parameter int unsigned AW    = WB_AW_DEFAULT,
  parameter int unsigned DW    = WB_DW_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       ex_valid_i,
  output logic                       ex_ready_o,
  input  logic [DW-1:0]              ex_result_i,
  input  logic [AW-1:0]              ex_rd_addr_i,
  input  logic                       ex_rd_we_i,
  output logic                       rf_we_o,
  output logic [AW-1:0]              rf_waddr_o,
  output logic [DW-1:0]              rf_wdata_o,
  input  logic                       rf_ready_i,
  input  logic [AW-1:0]              fwd_rs1_addr_i,
  output logic                       fwd_rs1_hit_o,
  output logic [DW-1:0]              fwd_rs1_data_o,
  input  logic [AW-1:0]              fwd_rs2_addr_i,
  output logic                       fwd_rs2_hit_o,
  output logic [DW-1:0]              fwd_rs2_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  input  logic                       fault_inject_i,
  output logic                       par_err_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t               mem_q [DEPTH];
  wb_entry_t               ent_d;
  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q, count_d;

  logic [DEPTH-1:0][AW-1:0] ent_rd;
  logic [DEPTH-1:0][DW-1:0] ent_data;
  logic [DEPTH-1:0]         ent_bad;
  logic [DEPTH-1:0]         fwd_valid;

  logic head_live, head_bad, store, pop;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_rd[i]   = mem_q[i].rd;
      ent_data[i] = mem_q[i].data;
`ifdef WB_RESULT_PARITY_EN
      ent_bad[i]  = wb_parity(mem_q[i].rd, mem_q[i].data) != mem_q[i].par;
`else
      ent_bad[i]  = 1'b0;
`endif
    end
  end

  always_comb begin
    ent_d      = '0;
    ent_d.rd   = ex_rd_addr_i;
    ent_d.data = ex_result_i;
`ifdef WB_RESULT_PARITY_EN
    ent_d.par  = wb_parity(ex_rd_addr_i, ex_result_i) ^ fault_inject_i;
`endif
  end

  assign ex_ready_o = count_q < CW'(DEPTH);
  assign head_live  = count_q != '0;
  assign head_bad   = head_live & ent_bad[rd_ptr_q];
  assign store      = ex_valid_i & ex_ready_o & ex_rd_we_i & (ex_rd_addr_i != '0);

  // A corrupted head is never written, but it is dropped so the drain keeps moving.
  assign rf_we_o    = head_live & ~head_bad;
  assign pop        = (rf_we_o & rf_ready_i) | head_bad;
  assign rf_waddr_o = ent_rd[rd_ptr_q];
  assign rf_wdata_o = ent_data[rd_ptr_q];
  assign count_o    = count_q;
  assign fwd_valid  = valid_q & ~ent_bad;

  always_comb begin
    valid_d = valid_q;
    if (pop)   valid_d[rd_ptr_q] = 1'b0;
    if (store) valid_d[wr_ptr_q] = 1'b1;
    count_d = count_q;
    case ({store, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      if (store) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) mem_q[wr_ptr_q] <= ent_d;
  end

`ifdef WB_RESULT_PARITY_EN
  logic par_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)         par_err_q <= 1'b0;
    else if (head_bad) par_err_q <= 1'b1;
  end

  assign par_err_o = par_err_q;
`else
  logic unused_fault_inject;
  assign unused_fault_inject = fault_inject_i;
  assign par_err_o           = 1'b0;
`endif

  ibex_wb_fwd_match #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_fwd_rs1 (
    .valid_i (fwd_valid),
    .rd_i    (ent_rd),
    .data_i  (ent_data),
    .wr_ptr_i(wr_ptr_q),
    .addr_i  (fwd_rs1_addr_i),
    .hit_o   (fwd_rs1_hit_o),
    .data_o  (fwd_rs1_data_o)
  );

  ibex_wb_fwd_match #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_fwd_rs2 (
    .valid_i (fwd_valid),
    .rd_i    (ent_rd),
    .data_i  (ent_data),
    .wr_ptr_i(wr_ptr_q),
    .addr_i  (fwd_rs2_addr_i),
    .hit_o   (fwd_rs2_hit_o),
    .data_o  (fwd_rs2_data_o)
  );

endmodule
